// File: rtl/ddj_key_event.sv
// ddj_key_event: turns the scanned 6-bit mole key vector into single-shot
// press events. Each key is stretched across scan gaps by a "seen" timer,
// debounced by a stability counter, and reported once per press through a
// small event FIFO that drains to the scorer over valid/ready.
module ddj_key_event #(
  parameter int SEEN_WIN   = 40,
  parameter int DEB_CNT    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       freq,
  input  logic       RESET,
  input  logic       enable,
  input  logic [5:0] key_data,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_key,
  output logic [5:0] held,
  output logic       evt_ovf
);

  localparam int NKEY = 6;
  localparam int TW   = $clog2(SEEN_WIN + 1);
  localparam int CW   = $clog2(DEB_CNT + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OW   = AW + 1;

  localparam logic [TW-1:0] SEEN_LD  = TW'(SEEN_WIN);
  localparam logic [TW-1:0] SEEN_ONE = TW'(1);
  localparam logic [CW-1:0] STAB_MAX = CW'(DEB_CNT);
  localparam logic [CW-1:0] STAB_PRE = CW'(DEB_CNT - 1);
  localparam logic [CW-1:0] STAB_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [OW-1:0] OCC_ONE  = OW'(1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  logic [NKEY-1:0] r_key_q;
  logic [TW-1:0]   r_seen [NKEY];
  logic [CW-1:0]   r_stab [NKEY];
  logic [NKEY-1:0] r_held;
  logic [NKEY-1:0] r_pend;
  logic            r_ovf;
  logic [2:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [OW-1:0]   r_count;

  logic [NKEY-1:0] w_present;
  logic [NKEY-1:0] w_qual;
  logic [NKEY-1:0] w_pend_nxt;
  logic            w_push_any;
  logic [2:0]      w_push_idx;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_ovf_set;

  assign evt_valid = (r_count != '0);
  assign evt_key   = r_mem[r_rd_ptr];
  assign held      = r_held;
  assign evt_ovf   = r_ovf;

  assign w_full = (r_count == OCC_FULL);
  assign w_pop  = evt_valid & evt_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push = w_push_any & (~w_full | w_pop);

  // Presence (raw bit or still inside the seen window) and press qualification.
  always_comb begin
    for (int i = 0; i < NKEY; i++) begin
      w_present[i] = r_key_q[i] | (r_seen[i] != '0);
      w_qual[i]    = w_present[i] & (r_stab[i] == STAB_PRE) & ~r_held[i];
    end
  end

  // Lowest-index pending key wins the single push slot of this edge.
  always_comb begin
    w_push_any = 1'b0;
    w_push_idx = '0;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_push_any = 1'b1;
        w_push_idx = 3'(i);
      end
    end
  end

  // Next pend vector; a qualify on a key whose pend is still waiting is dropped.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_set  = 1'b0;
    for (int i = 0; i < NKEY; i++) begin
      if (w_push && (w_push_idx == 3'(i))) begin
        w_pend_nxt[i] = 1'b0;
      end
      if (w_qual[i]) begin
        if (w_pend_nxt[i]) begin
          w_ovf_set = 1'b1;
        end else begin
          w_pend_nxt[i] = 1'b1;
        end
      end
    end
  end

  // Per-key input register, seen timer, stability counter, held and pend flags.
  always_ff @(posedge freq or posedge RESET) begin
    if (RESET) begin
      r_key_q <= '0;
      r_held  <= '0;
      r_pend  <= '0;
      for (int i = 0; i < NKEY; i++) begin
        r_seen[i] <= '0;
        r_stab[i] <= '0;
      end
    end else begin
      r_key_q <= key_data;
      if (!enable) begin
        r_held <= '0;
        r_pend <= '0;
        for (int i = 0; i < NKEY; i++) begin
          r_seen[i] <= '0;
          r_stab[i] <= '0;
        end
      end else begin
        r_pend <= w_pend_nxt;
        for (int i = 0; i < NKEY; i++) begin
          if (r_key_q[i]) begin
            r_seen[i] <= SEEN_LD;
          end else if (r_seen[i] != '0) begin
            r_seen[i] <= r_seen[i] - SEEN_ONE;
          end
          if (w_present[i]) begin
            if (r_stab[i] != STAB_MAX) begin
              r_stab[i] <= r_stab[i] + STAB_ONE;
            end
            if (w_qual[i]) begin
              r_held[i] <= 1'b1;
            end
          end else begin
            r_stab[i] <= '0;
            r_held[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Event FIFO storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge freq or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else if (!enable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_idx;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ddj_key_event.sv
// Scoreboard bench for ddj_key_event: stimulus pushes expected key indices,
// a negedge monitor pops and compares on every valid&ready handshake.
module tb_ddj_key_event;

  logic       freq = 1'b0;
  logic       RESET;
  logic       enable;
  logic [5:0] key_data;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic [5:0] held;
  logic       evt_ovf;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mon_exp;

  ddj_key_event #(
    .SEEN_WIN  (40),
    .DEB_CNT   (20),
    .FIFO_DEPTH(4)
  ) dut (
    .freq     (freq),
    .RESET    (RESET),
    .enable   (enable),
    .key_data (key_data),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_key  (evt_key),
    .held     (held),
    .evt_ovf  (evt_ovf)
  );

  always #5 freq = ~freq;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read there
  // (after the DUT has updated) or at the falling edge by the monitor.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge freq);
      #2;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    evt_ready = 1'b1;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    step(2);
    chk({name, "_missing"}, 32'(exp_q.size()), 0);
    chk({name, "_empty"}, 32'(evt_valid), 0);
  endtask

  task automatic settle();
    key_data = 6'b0;
    step(50);
  endtask

  // Monitor: every handshake must match the oldest expected event.
  always @(negedge freq) begin
    if (!RESET && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got key %0d, expected no event", evt_key);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("event_key", 32'(evt_key), 32'(mon_exp));
      end
    end
  end

  initial begin
    RESET     = 1'b1;
    enable    = 1'b1;
    key_data  = 6'b0;
    evt_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_key", 32'(evt_key), 0);
    chk("rst_held", 32'(held), 0);
    chk("rst_ovf", 32'(evt_ovf), 0);
    step(3);
    RESET = 1'b0;
    step(2);
    chk("idle_valid", 32'(evt_valid), 0);

    // Scan-style press of key 2: 10 high / 20 low, presence bridges the gaps.
    evt_ready = 1'b1;
    exp_q.push_back(2);
    for (int c = 0; c < 236; c++) begin
      key_data = (c < 200 && (c % 30) < 10) ? 6'b000100 : 6'b000000;
      step(1);
      if (c == 20) chk("scan_valid_e20", 32'(evt_valid), 0);
      if (c == 21) begin
        chk("scan_valid_e21", 32'(evt_valid), 1);
        chk("scan_key_e21", 32'(evt_key), 2);
      end
      if (c == 100) chk("scan_held_mid", 32'(held), 32'h04);
      if (c == 230) chk("scan_held_e230", 32'(held[2]), 1);
      if (c == 231) chk("scan_held_e231", 32'(held[2]), 0);
    end
    drain("scan", 10);

    // A 10-clock pulse is stretched by the seen timer to 50 present clocks,
    // which exceeds the debounce count, so it still qualifies once.
    exp_q.push_back(0);
    for (int c = 0; c < 110; c++) begin
      key_data = (c < 10) ? 6'b000001 : 6'b000000;
      step(1);
      if (c == 50) chk("pulse_held_e50", 32'(held[0]), 1);
      if (c == 51) chk("pulse_held_e51", 32'(held[0]), 0);
    end
    drain("pulse", 10);

    // Keys 1 and 4 qualify together; pushed on successive edges, low index first.
    evt_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      key_data = 6'b010010;
      step(1);
      if (c == 20) chk("simul_valid_e20", 32'(evt_valid), 0);
      if (c == 21) begin
        chk("simul_valid_e21", 32'(evt_valid), 1);
        chk("simul_key_e21", 32'(evt_key), 1);
      end
      if (c == 22) chk("simul_key_e22", 32'(evt_key), 1);
    end
    exp_q.push_back(1);
    exp_q.push_back(4);
    drain("simul", 10);
    chk("simul_held", 32'(held), 32'h12);
    settle();
    chk("simul_released", 32'(held), 0);

    // Five single presses with the scorer stalled: four queue, the fifth waits.
    evt_ready = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (c < 25)       key_data = 6'b100000;
      else if (c < 50)  key_data = 6'b001000;
      else if (c < 75)  key_data = 6'b000010;
      else if (c < 100) key_data = 6'b000001;
      else if (c < 125) key_data = 6'b000100;
      else              key_data = 6'b000000;
      step(1);
    end
    chk("full_valid", 32'(evt_valid), 1);
    chk("full_head", 32'(evt_key), 5);
    chk("full_ovf", 32'(evt_ovf), 0);
    exp_q.push_back(5);
    exp_q.push_back(3);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(2);
    drain("full", 20);
    settle();

    // Overflow: key 3 waits in pend behind a full FIFO, releases and re-qualifies.
    evt_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c < 25)       key_data = 6'b000001;
      else if (c < 50)  key_data = 6'b000010;
      else if (c < 75)  key_data = 6'b000100;
      else if (c < 100) key_data = 6'b010000;
      else if (c < 125) key_data = 6'b001000;
      else if (c < 170) key_data = 6'b000000;
      else if (c < 195) key_data = 6'b001000;
      else              key_data = 6'b000000;
      step(1);
      if (c == 160) chk("ovf_held3_before_release", 32'(held[3]), 1);
      if (c == 185) chk("ovf_before", 32'(evt_ovf), 0);
      if (c == 195) chk("ovf_after", 32'(evt_ovf), 1);
    end
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(4);
    exp_q.push_back(3);
    drain("ovf", 20);
    chk("ovf_sticky", 32'(evt_ovf), 1);
    settle();

    // enable drop flushes queued events; keys still down re-qualify afterwards.
    evt_ready = 1'b0;
    key_data  = 6'b000110;
    step(25);
    chk("en_queued_valid", 32'(evt_valid), 1);
    chk("en_queued_key", 32'(evt_key), 1);
    enable = 1'b0;
    step(1);
    chk("en_drop_valid", 32'(evt_valid), 0);
    chk("en_drop_held", 32'(held), 0);
    chk("en_drop_ovf", 32'(evt_ovf), 1);
    enable = 1'b1;
    step(20);
    chk("en_rise_valid_early", 32'(evt_valid), 0);
    step(1);
    chk("en_rise_valid", 32'(evt_valid), 1);
    chk("en_rise_key", 32'(evt_key), 1);
    exp_q.push_back(1);
    exp_q.push_back(2);
    drain("en_rise", 10);
    settle();

    // Asynchronous reset with an event at the head and a key mid-debounce.
    evt_ready = 1'b0;
    key_data  = 6'b100000;
    step(25);
    key_data = 6'b000001;
    step(10);
    chk("pre_rst_valid", 32'(evt_valid), 1);
    RESET    = 1'b1;
    key_data = 6'b000000;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_key", 32'(evt_key), 0);
    chk("mid_rst_held", 32'(held), 0);
    chk("mid_rst_ovf", 32'(evt_ovf), 0);
    step(2);
    RESET     = 1'b0;
    evt_ready = 1'b1;
    step(30);
    chk("post_rst_valid", 32'(evt_valid), 0);
    drain("post_rst", 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
